uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised receive FIFO between the UART receiver and the core's input-byte request path. It generalises the single-width byte buffer with configurable data width and depth, full/empty/level status, sticky overflow detection, synchronous flush and an almost-full flag. The write side is push-only: the UART cannot be back-pressured, so pushes into a full FIFO are dropped and flagged. The read side is a request/valid handshake: the core pulses a request and gets exactly one word, strobed for one cycle.

Parameters:
DWIDTH, 8, data word width in bits
DEPTH_LOG2, 12, log2 of FIFO depth (depth = 2**DEPTH_LOG2 words)
AFULL_THRESH, 2**DEPTH_LOG2-16, level at or above which afull is asserted

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  reset, asynchronous, active-low
din  in  DWIDTH  write data from UART receiver
din_valid  in  1  push strobe, one word per high cycle
rd_req  in  1  read request, sampled only in state IDLE
dout  out  DWIDTH  read data, meaningful only while dout_valid=1
dout_valid  out  1  one-cycle strobe: dout holds the requested word
flush  in  1  synchronous clear of FIFO contents
ovf_clr  in  1  clears the sticky overflow flag
empty  out  1  level == 0
full  out  1  level == 2**DEPTH_LOG2
afull  out  1  level >= AFULL_THRESH
level  out  DEPTH_LOG2+1  current occupancy
overflow  out  1  sticky: a push was dropped

Behaviour:
- Reset (rstn low, async): wr_ptr=0, rd_ptr=0, level=0, state=IDLE, dout=0, dout_valid=0, overflow=0. empty=1, full=0, afull=0. Memory contents are undefined and not reset.
- Push: din_valid=1 and full=0 -> mem[wr_ptr]<=din, wr_ptr+1. Pointers are DEPTH_LOG2 bits wide and wrap modulo depth.
- Push with full=1: word dropped, wr_ptr unchanged, overflow<=1.
- Full check uses the pre-edge level. A push and a pop in the same cycle while full still drops the push.
- Level:
  - +1 on an accepted push.
  - -1 on a pop (VALID cycle).
  - Unchanged when both occur in the same cycle.
  - Flags are combinational from level.
- Read FSM, states IDLE, WAIT, FETCH, VALID:
  - IDLE: rd_req=1 and level!=0 -> FETCH. rd_req=1 and level==0 -> WAIT. Otherwise stay.
  - WAIT: level!=0 -> FETCH. rd_req is ignored.
  - FETCH: dout<=mem[rd_ptr] (registered read) -> VALID.
  - VALID: dout_valid=1 for this cycle only, dout stable. At the end of the cycle rd_ptr+1 and level-1 -> IDLE.
- Latency: rd_req at cycle t with data present gives dout_valid at t+2. A word pushed at cycle w into an empty FIFO with a pending request gives dout_valid at w+3.
- rd_req outside IDLE is ignored. Requests are not queued.
- dout_valid is a registered output and is never high in two consecutive cycles.
- flush=1 (synchronous, highest priority after reset):
  - wr_ptr=rd_ptr=level=0, state=IDLE, dout_valid=0.
  - A push or pop in the same cycle is discarded.
  - overflow is unaffected.
- ovf_clr=1: overflow<=0. A dropped push in the same cycle sets overflow (set wins).
- Reset asserted mid-read aborts the request. No dout_valid strobe follows reset release until a new rd_req.

Optional Feature:
UART_FIFO_HWM_EN:
- Defined: adds output hwm (DEPTH_LOG2+1 bits), the high-water mark.
  - hwm<=max(hwm, next level) every cycle.
  - Reset to 0 by rstn and by flush. Unaffected by ovf_clr.
- Undefined: no hwm port and no related logic. All other behaviour is identical.

Test Plan:
- Reset, push 0x41 at cycle 0, rd_req at cycle 3 -> dout_valid=1 with dout=0x41 at cycle 5. level 1->0 after that cycle, empty=1.
- rd_req on an empty FIFO, then push 0x5A at cycle w -> dout_valid with 0x5A at w+3. Extra rd_req pulses during WAIT produce no second strobe.
- Push 2**DEPTH_LOG2 words (0..N-1 mod 256), then one more -> full=1, overflow=1, last word dropped. Read all -> data 0..N-1 in order.
- Check wrap-around: after the full test, push/read 10 words -> correct order; afull toggles exactly at AFULL_THRESH.
- Push 5 words, flush mid-read (during FETCH) -> level=0, no dout_valid. overflow unchanged. ovf_clr coinciding with a dropped push -> overflow stays 1.
- With UART_FIFO_HWM_EN: push 7, read 3, push 2 -> hwm=7. After flush -> hwm=0.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Receive FIFO between the UART receiver and the core's byte-request path.
//   The write side is push-only: the UART cannot be stalled, so a push into a
//   full FIFO is dropped and latched in the sticky overflow flag. The read side
//   is a request/valid handshake: one rd_req pulse returns exactly one word,
//   strobed on dout_valid for a single cycle.
//
//   Optional feature macro: UART_FIFO_HWM_EN
//     When defined, adds output hwm, the high-water mark of the FIFO level.
//
// Parameters
//   DWIDTH       data word width
//   DEPTH_LOG2   log2 of FIFO depth
//   AFULL_THRESH level at or above which afull is asserted
//
// Ports
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   din         write data from the UART receiver
//   din_valid   push strobe, one word per high cycle
//   rd_req      read request, only honoured while the read FSM is idle
//   dout        read data, meaningful while dout_valid is high
//   dout_valid  one-cycle strobe for the requested word
//   flush       synchronous clear of FIFO contents and read FSM
//   ovf_clr     clears the sticky overflow flag
//   empty/full/afull  status flags derived from level
//   level       current occupancy
//   overflow    sticky: a push was dropped
//   hwm         (UART_FIFO_HWM_EN only) highest level seen since reset/flush
module uart_rx_fifo #(
    parameter int DWIDTH       = 8,
    parameter int DEPTH_LOG2   = 12,
    parameter int AFULL_THRESH = 2**DEPTH_LOG2 - 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DWIDTH-1:0]     din,
    input  logic                  din_valid,
    input  logic                  rd_req,
    output logic [DWIDTH-1:0]     dout,
    output logic                  dout_valid,
    input  logic                  flush,
    input  logic                  ovf_clr,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
`ifdef UART_FIFO_HWM_EN
    ,
    output logic [DEPTH_LOG2:0]   hwm
`endif
);

    localparam int LW = DEPTH_LOG2 + 1;
    localparam logic [LW-1:0] DEPTH_LVL = LW'(2**DEPTH_LOG2);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_THRESH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH,
        S_VALID
    } state_t;

    state_t                  state;
    state_t                  state_d;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [LW-1:0]           level_d;
    logic                    push_ok;
    logic                    pop;

    logic [DWIDTH-1:0]       mem [2**DEPTH_LOG2];

    assign empty = (level == '0);
    assign full  = (level == DEPTH_LVL);
    assign afull = (level >= AFULL_LVL);

    // Full is judged on the pre-edge level, so a simultaneous pop does not
    // make room for a push that arrives while full.
    assign push_ok = din_valid && !full;
    assign pop     = (state == S_VALID);

    always_comb begin
        level_d = level;
        if (flush) begin
            level_d = '0;
        end else if (push_ok && !pop) begin
            level_d = level + 1'b1;
        end else if (!push_ok && pop) begin
            level_d = level - 1'b1;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (rd_req) state_d = empty ? S_WAIT : S_FETCH;
            S_WAIT:  if (!empty) state_d = S_FETCH;
            S_FETCH: state_d = S_VALID;
            S_VALID: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    // Storage is not reset; only words below level are ever read.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_d;
            level <= level_d;
            // dout_valid mirrors entry into VALID; flush cancels it.
            dout_valid <= (state == S_FETCH) && !flush;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
            end

            if ((state == S_FETCH) && !flush) dout <= mem[rd_ptr];

            // A drop in the same cycle as ovf_clr keeps the flag set.
            if (din_valid && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef UART_FIFO_HWM_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hwm <= '0;
        end else if (flush) begin
            hwm <= '0;
        end else if (level_d > hwm) begin
            hwm <= level_d;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DL2   = 12;
    localparam int DEPTH = 2**DL2;
    localparam int TH    = DEPTH - 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic [DW-1:0]    din = '0;
    logic             din_valid = 1'b0;
    logic             rd_req = 1'b0;
    logic [DW-1:0]    dout;
    logic             dout_valid;
    logic             flush = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             empty;
    logic             full;
    logic             afull;
    logic [DL2:0]     level;
    logic             overflow;
`ifdef UART_FIFO_HWM_EN
    logic [DL2:0]     hwm;
`endif

    uart_rx_fifo #(
        .DWIDTH      (DW),
        .DEPTH_LOG2  (DL2),
        .AFULL_THRESH(TH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din       (din),
        .din_valid (din_valid),
        .rd_req    (rd_req),
        .dout      (dout),
        .dout_valid(dout_valid),
        .flush     (flush),
        .ovf_clr   (ovf_clr),
        .empty     (empty),
        .full      (full),
        .afull     (afull),
        .level     (level),
        .overflow  (overflow)
`ifdef UART_FIFO_HWM_EN
        ,
        .hwm       (hwm)
`endif
    );

    always #5 clk = ~clk;

    int unsigned   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            n_cmp = 0;
    int            n_err = 0;
    int            strobes = 0;
    int unsigned   last_strobe_cyc = 0;
    logic          prev_valid = 1'b0;
    logic [DW-1:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe pops the oldest expected word.
    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rstn === 1'b1) begin
            if (dout_valid === 1'b1) begin
                strobes++;
                last_strobe_cyc = cyc;
                check("dout_valid_single_cycle", 64'(prev_valid), 64'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_strobe: got dout 0x%0h, expected no strobe (cycle %0d)", dout, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", 64'(dout), 64'(e));
                end
            end
            prev_valid = dout_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // The bench model's queue size equals the DUT level at this point of the
    // cycle, so it decides whether the push will be accepted.
    task automatic push(input logic [DW-1:0] b);
        din       = b;
        din_valid = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        tick();
        din_valid = 1'b0;
    endtask

    task automatic read_one();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_strobes(input int target, input int bound);
        int n = 0;
        while (strobes < target && n < bound) begin
            tick();
            n++;
        end
        check("strobe_arrived", 64'(strobes >= target), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        int          s0;

        // Reset state
        tick();
        tick();
        check("rst_dout_valid", 64'(dout_valid), 64'd0);
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_afull", 64'(afull), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rstn = 1'b1;
        tick();

        // Push 0x41, request 3 cycles later, strobe two cycles after request
        push(8'h41);
        check("t1_level_after_push", 64'(level), 64'd1);
        tick();
        tick();
        t = cyc;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wait_strobes(1, 10);
        check("t1_latency", 64'(last_strobe_cyc - t), 64'd2);
        check("t1_level_after_read", 64'(level), 64'd0);
        check("t1_empty_after_read", 64'(empty), 64'd1);

        // Request on empty FIFO, extra requests while waiting, then push
        s0 = strobes;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        t = cyc;
        push(8'h5A);
        wait_strobes(s0 + 1, 10);
        check("t2_latency", 64'(last_strobe_cyc - t), 64'd3);
        repeat (6) tick();
        check("t2_single_strobe", 64'(strobes), 64'(s0 + 1));
        check("t2_empty", 64'(empty), 64'd1);

        // Fill to full, watching afull cross the threshold
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(i));
            check("fill_afull", 64'(afull), 64'(exp_q.size() >= TH));
        end
        check("full_level", 64'(level), 64'(DEPTH));
        check("full_flag", 64'(full), 64'd1);
        check("full_ovf_before_drop", 64'(overflow), 64'd0);
        push(8'hEE);
        check("drop_overflow", 64'(overflow), 64'd1);
        check("drop_level", 64'(level), 64'(DEPTH));

        // ovf_clr together with a dropped push keeps overflow set
        ovf_clr = 1'b1;
        push(8'hEF);
        ovf_clr = 1'b0;
        check("ovf_clr_set_wins", 64'(overflow), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr_clears", 64'(overflow), 64'd0);

        // Push during the VALID cycle while full is still dropped
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        push(8'hED);
        check("valid_push_dropped_ovf", 64'(overflow), 64'd1);
        check("valid_push_dropped_level", 64'(level), 64'(DEPTH - 1));

        // Drain everything, data checked in order by the monitor
        for (int i = 1; i < DEPTH; i++) begin
            read_one();
            check("drain_afull", 64'(afull), 64'(exp_q.size() >= TH));
        end
        check("drain_level", 64'(level), 64'd0);
        check("drain_empty", 64'(empty), 64'd1);
        check("drain_strobes", 64'(strobes), 64'(s0 + 1 + DEPTH));

        // Wrap-around: pointers crossed the top of memory during the fill
        for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
        check("wrap_level", 64'(level), 64'd10);
        for (int i = 0; i < 10; i++) read_one();
        check("wrap_empty", 64'(empty), 64'd1);

        // Flush while FETCH is in progress
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        flush = 1'b1;
        exp_q.delete();
        tick();
        flush = 1'b0;
        s0 = strobes;
        repeat (5) tick();
        check("flush_no_strobe", 64'(strobes), 64'(s0));
        check("flush_level", 64'(level), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);
        check("flush_overflow_kept", 64'(overflow), 64'd1);
        push(8'h77);
        read_one();
        check("post_flush_read", 64'(strobes), 64'(s0 + 1));

        // Reset in the middle of a read aborts it
        push(8'h99);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        #2;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check("rst_async_level", 64'(level), 64'd0);
        check("rst_async_overflow", 64'(overflow), 64'd0);
        tick();
        rstn = 1'b1;
        s0 = strobes;
        repeat (5) tick();
        check("rst_abort_no_strobe", 64'(strobes), 64'(s0));
        check("rst_abort_empty", 64'(empty), 64'd1);

`ifdef UART_FIFO_HWM_EN
        check("hwm_after_reset", 64'(hwm), 64'd0);
        for (int i = 0; i < 7; i++) push(8'h10 + 8'(i));
        for (int i = 0; i < 3; i++) read_one();
        push(8'h20);
        push(8'h21);
        check("hwm_level", 64'(level), 64'd6);
        check("hwm_value", 64'(hwm), 64'd7);
        do_flush();
        check("hwm_after_flush", 64'(hwm), 64'd0);
`else
        do_flush();
`endif
        check("final_empty", 64'(empty), 64'd1);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
